swd_host: RTL and testbench

Synthesizable Serial Wire Debug host engine. It accepts DP/AP transfer commands on a valid/ready interface and serializes them onto SWCLKTCK/SWDITMS. It returns the target's ACK and read data from SWDO. It sits opposite the SoC's SWD target port, either as a bench-side probe or as an on-chip debug bridge.

---
 rtl/swd_host_if.sv | 24 ++
 rtl/swd_host.sv | 168 ++++++++++++++++
 tb/tb_swd_host.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/swd_host_if.sv
// Command/response handshake between an SWD requester and the swd_host engine.
interface swd_host_if;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [1:0]  CMD_OP;
  logic        CMD_APnDP;
  logic        CMD_RnW;
  logic [1:0]  CMD_ADDR;
  logic [31:0] CMD_WDATA;
  logic        RSP_VALID;
  logic [2:0]  RSP_ACK;
  logic [31:0] RSP_RDATA;
  logic        RSP_PERR;

  modport master (
    output CMD_VALID, CMD_OP, CMD_APnDP, CMD_RnW, CMD_ADDR, CMD_WDATA,
    input  CMD_READY, RSP_VALID, RSP_ACK, RSP_RDATA, RSP_PERR
  );

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_APnDP, CMD_RnW, CMD_ADDR, CMD_WDATA,
    output CMD_READY, RSP_VALID, RSP_ACK, RSP_RDATA, RSP_PERR
  );
endinterface

// File: rtl/swd_host.sv
// SWD host engine: serializes DP/AP transfers and line resets onto SWCLKTCK/SWDITMS,
// one bit per slot of 2*CLK_DIV clocks, and returns ACK / read data / parity status.
module swd_host #(
  parameter int CLK_DIV     = 4,
  parameter int IDLE_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  swd_host_if.slave  bus,
  output logic       SWCLKTCK,
  output logic       SWDITMS,
  output logic       SWDIOOE,
  input  logic       SWDO,
  input  logic       SWDOEN
);
  localparam int DW = $clog2(2 * CLK_DIV);
  localparam logic [DW-1:0] DIV_LO  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_END = DW'(2 * CLK_DIV - 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_START, ST_REQ, ST_TRN1, ST_ACK, ST_RDATA, ST_RPAR,
    ST_TRN2, ST_WDATA, ST_WPAR, ST_LRST, ST_IDLES, ST_DONE
  } state_e;

  localparam state_e ST_IDLE_TGT = (IDLE_CYCLES == 0) ? ST_DONE : ST_IDLES;

  state_e        state_q, nst_d;
  logic [DW-1:0] div_q;
  logic [5:0]    cnt_q, ncnt_d;
  logic          lr_q, rnw_q, rpar_q;
  logic [7:0]    req_q;
  logic [31:0]   wdata_q, rdata_q;
  logic [2:0]    ack_q;
  logic          sck_q, di_q, oe_q, ready_q, rvalid_q, rperr_q;
  logic [2:0]    rack_q;
  logic [31:0]   rrdata_q;
  logic          bit_d, oe_d, ack_ok, rd_ok;

  // Target drive enable is informational; sampling relies on slot timing only.
  logic unused_swdoen;
  assign unused_swdoen = SWDOEN;

  assign ack_ok = (ack_q == 3'b001);
  assign rd_ok  = rnw_q && ack_ok && !lr_q;

  // Phase and slot index of the slot that follows the current one.
  always_comb begin
    nst_d  = state_q;
    ncnt_d = cnt_q + 6'd1;
    case (state_q)
      ST_START: begin nst_d = lr_q ? ST_LRST : ST_REQ; ncnt_d = '0; end
      ST_REQ:   if (cnt_q == 6'd7) begin nst_d = ST_TRN1; ncnt_d = '0; end
      ST_TRN1:  begin nst_d = ST_ACK; ncnt_d = '0; end
      ST_ACK:   if (cnt_q == 6'd2) begin
                  nst_d  = (ack_ok && rnw_q) ? ST_RDATA : ST_TRN2;
                  ncnt_d = '0;
                end
      ST_RDATA: if (cnt_q == 6'd31) begin nst_d = ST_RPAR; ncnt_d = '0; end
      ST_RPAR:  begin nst_d = ST_TRN2; ncnt_d = '0; end
      ST_TRN2:  begin nst_d = (ack_ok && !rnw_q) ? ST_WDATA : ST_IDLE_TGT; ncnt_d = '0; end
      ST_WDATA: if (cnt_q == 6'd31) begin nst_d = ST_WPAR; ncnt_d = '0; end
      ST_WPAR:  begin nst_d = ST_IDLE_TGT; ncnt_d = '0; end
      ST_LRST:  if (cnt_q == 6'd55) begin nst_d = ST_IDLE_TGT; ncnt_d = '0; end
      ST_IDLES: if (cnt_q == 6'(IDLE_CYCLES - 1)) begin nst_d = ST_DONE; ncnt_d = '0; end
      default: ;
    endcase
  end

  // Line level for the next slot; released phases float high through the pull-up.
  always_comb begin
    bit_d = 1'b1;
    oe_d  = 1'b0;
    case (nst_d)
      ST_REQ:             begin bit_d = req_q[ncnt_d[2:0]];   oe_d = 1'b1; end
      ST_WDATA:           begin bit_d = wdata_q[ncnt_d[4:0]]; oe_d = 1'b1; end
      ST_WPAR:            begin bit_d = ^wdata_q;             oe_d = 1'b1; end
      ST_LRST:            begin bit_d = 1'b1;                 oe_d = 1'b1; end
      ST_IDLES, ST_DONE:  begin bit_d = 1'b0;                 oe_d = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      cnt_q    <= '0;
      lr_q     <= 1'b0;
      rnw_q    <= 1'b0;
      req_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ack_q    <= '0;
      rpar_q   <= 1'b0;
      sck_q    <= 1'b0;
      di_q     <= 1'b0;
      oe_q     <= 1'b1;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rack_q   <= '0;
      rrdata_q <= '0;
      rperr_q  <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.CMD_VALID) begin
            state_q <= ST_START;
            ready_q <= 1'b0;
            lr_q    <= (bus.CMD_OP != 2'b00);
            rnw_q   <= bus.CMD_RnW;
            wdata_q <= bus.CMD_WDATA;
            ack_q   <= '0;
            req_q   <= {1'b1, 1'b0,
                        bus.CMD_APnDP ^ bus.CMD_RnW ^ bus.CMD_ADDR[0] ^ bus.CMD_ADDR[1],
                        bus.CMD_ADDR[1], bus.CMD_ADDR[0], bus.CMD_RnW, bus.CMD_APnDP, 1'b1};
          end else begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        ST_START: begin
          state_q <= nst_d;
          cnt_q   <= ncnt_d;
          div_q   <= '0;
          di_q    <= bit_d;
          oe_q    <= oe_d;
        end
        default: begin
          div_q <= div_q + DW'(1);
          if (div_q == DIV_LO) begin
            sck_q <= 1'b1;
            case (state_q)
              ST_ACK:   ack_q[cnt_q[1:0]]   <= SWDO;
              ST_RDATA: rdata_q[cnt_q[4:0]] <= SWDO;
              ST_RPAR:  rpar_q              <= SWDO;
              default: ;
            endcase
          end
          if (div_q == DIV_END) begin
            div_q   <= '0;
            sck_q   <= 1'b0;
            state_q <= nst_d;
            cnt_q   <= ncnt_d;
            di_q    <= bit_d;
            oe_q    <= oe_d;
            if (nst_d == ST_DONE) begin
              rvalid_q <= 1'b1;
              ready_q  <= 1'b1;
              rack_q   <= lr_q ? 3'b000 : ack_q;
              rrdata_q <= rd_ok ? rdata_q : 32'd0;
              rperr_q  <= rd_ok & (rpar_q ^ (^rdata_q));
            end
          end
        end
      endcase
    end
  end

  assign SWCLKTCK      = sck_q;
  assign SWDITMS       = di_q;
  assign SWDIOOE       = oe_q;
  assign bus.CMD_READY = ready_q;
  assign bus.RSP_VALID = rvalid_q;
  assign bus.RSP_ACK   = rack_q;
  assign bus.RSP_RDATA = rrdata_q;
  assign bus.RSP_PERR  = rperr_q;
endmodule

// File: tb/tb_swd_host.sv
// Self-checking bench for swd_host: slot-indexed target model plus a field-level
// reference of the expected host bit stream, response and latency.
module tb_swd_host;
  localparam int CLK_DIV = 4;
  localparam int IDLE_CYCLES = 2;
  localparam int S = 2 * CLK_DIV;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic SWCLKTCK, SWDITMS, SWDIOOE, SWDO, SWDOEN;

  swd_host_if bus();

  swd_host #(.CLK_DIV(CLK_DIV), .IDLE_CYCLES(IDLE_CYCLES)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus),
    .SWCLKTCK(SWCLKTCK), .SWDITMS(SWDITMS), .SWDIOOE(SWDIOOE),
    .SWDO(SWDO), .SWDOEN(SWDOEN)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Target: SWDO for absolute slot n comes from plan[n]; undriven slots read 1.
  logic plan [4096];
  int   slot_total = 0;
  logic host_q[$];
  logic oe_q[$];
  assign SWDO   = (slot_total < 4096) ? plan[slot_total] : 1'b1;
  assign SWDOEN = 1'b0;

  always @(posedge SWCLKTCK) begin
    host_q.push_back(SWDITMS);
    oe_q.push_back(SWDIOOE);
    slot_total = slot_total + 1;
  end

  logic [127:0] exp_stream, exp_oe, obs_stream, obs_oe;
  int           exp_n, obs_n, exp_lat, obs_lat, acc_cyc, rsp_cyc, base;
  logic [2:0]   exp_ack;
  logic [31:0]  exp_rdata;
  logic         exp_perr;

  task automatic put(input logic v, input logic o);
    exp_stream[exp_n] = v;
    exp_oe[exp_n]     = o;
    exp_n++;
  endtask

  // Reference transfer: request byte, turnarounds, ACK, data phase and idle tail.
  task automatic model_xfer(input logic ap, input logic rnw, input logic [1:0] addr,
                            input logic [31:0] wd, input logic [2:0] ack,
                            input logic [31:0] td, input logic flip);
    logic ok, par;
    logic [7:0] req;
    ok  = (ack == 3'b001);
    par = ap ^ rnw ^ addr[0] ^ addr[1];
    req = 8'd129 + 8'(ap) * 8'd2 + 8'(rnw) * 8'd4 + 8'(addr) * 8'd8 + 8'(par) * 8'd32;
    exp_n = 0; exp_stream = '0; exp_oe = '0;
    for (int i = 0; i < 8; i++) put(req[i], 1'b1);
    put(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin put(1'b1, 1'b0); plan[base + 9 + i] = ack[i]; end
    if (rnw && ok) begin
      for (int i = 0; i < 32; i++) begin put(1'b1, 1'b0); plan[base + 12 + i] = td[i]; end
      put(1'b1, 1'b0);
      plan[base + 44] = (^td) ^ flip;
      put(1'b1, 1'b0);
    end else if (ok) begin
      put(1'b1, 1'b0);
      for (int i = 0; i < 32; i++) put(wd[i], 1'b1);
      put(^wd, 1'b1);
    end else begin
      put(1'b1, 1'b0);
    end
    for (int i = 0; i < IDLE_CYCLES; i++) put(1'b0, 1'b1);
    exp_ack   = ack;
    exp_rdata = (rnw && ok) ? td : 32'd0;
    exp_perr  = rnw && ok && flip;
    exp_lat   = exp_n * S + 1;
  endtask

  task automatic model_lreset();
    exp_n = 0; exp_stream = '0; exp_oe = '0;
    for (int i = 0; i < 56; i++) put(1'b1, 1'b1);
    for (int i = 0; i < IDLE_CYCLES; i++) put(1'b0, 1'b1);
    exp_ack = 3'b000; exp_rdata = 32'd0; exp_perr = 1'b0;
    exp_lat = exp_n * S + 1;
  endtask

  // Called #1 after a clock edge; returns #1 after the acceptance edge.
  task automatic issue(input logic [1:0] op, input logic ap, input logic rnw,
                       input logic [1:0] addr, input logic [31:0] wd);
    bus.CMD_OP = op; bus.CMD_APnDP = ap; bus.CMD_RnW = rnw;
    bus.CMD_ADDR = addr; bus.CMD_WDATA = wd; bus.CMD_VALID = 1'b1;
    for (int i = 0; i < 4000 && bus.CMD_READY !== 1'b1; i++) begin @(posedge CLK); #1; end
    if (bus.CMD_READY !== 1'b1) begin
      checks++; errors++;
      $display("FAIL accept_timeout: CMD_READY=%b required 1", bus.CMD_READY);
    end
    @(posedge CLK); #1;
    acc_cyc = cyc;
    bus.CMD_VALID = 1'b0;
  endtask

  task automatic wait_rsp();
    int i;
    for (i = 0; i < 3000; i++) begin
      @(posedge CLK); #1;
      if (bus.RSP_VALID === 1'b1) break;
    end
    rsp_cyc = cyc;
    obs_lat = rsp_cyc - acc_cyc;
    if (i == 3000) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: no RSP_VALID within 3000 cycles");
    end
  endtask

  task automatic pack();
    obs_n = host_q.size() - base;
    obs_stream = '0; obs_oe = '0;
    for (int k = 0; k < obs_n && k < 128; k++) begin
      obs_stream[k] = host_q[base + k];
      obs_oe[k]     = oe_q[base + k];
    end
  endtask

  task automatic run_xfer(input logic ap, input logic rnw, input logic [1:0] addr,
                          input logic [31:0] wd, input logic [2:0] ack,
                          input logic [31:0] td, input logic flip);
    base = host_q.size();
    model_xfer(ap, rnw, addr, wd, ack, td, flip);
    issue(2'b00, ap, rnw, addr, wd);
    wait_rsp();
    pack();
  endtask

  task automatic test_reset();
    checks++;
    if ({SWCLKTCK, SWDITMS, SWDIOOE} !== 3'b001) begin errors++;
      $display("FAIL reset_pins: sck/di/oe=%b required 001", {SWCLKTCK, SWDITMS, SWDIOOE}); end
    checks++;
    if ({bus.CMD_READY, bus.RSP_VALID} !== 2'b10) begin errors++;
      $display("FAIL reset_hs: ready/valid=%b required 10", {bus.CMD_READY, bus.RSP_VALID}); end
    checks++;
    if ({bus.RSP_ACK, bus.RSP_RDATA, bus.RSP_PERR} !== 36'd0) begin errors++;
      $display("FAIL reset_rsp: ack=%b rdata=%h perr=%b required zeros",
               bus.RSP_ACK, bus.RSP_RDATA, bus.RSP_PERR); end
  endtask

  task automatic test_idcode_read();
    logic [31:0] held;
    run_xfer(1'b0, 1'b1, 2'b00, 32'd0, 3'b001, 32'h0BC11477, 1'b0);
    checks++;
    if (obs_stream[7:0] !== 8'hA5) begin errors++;
      $display("FAIL idcode_req: got %h required a5", obs_stream[7:0]); end
    checks++;
    if (bus.RSP_ACK !== 3'b001 || bus.RSP_RDATA !== 32'h0BC11477 || bus.RSP_PERR !== 1'b0) begin
      errors++;
      $display("FAIL idcode_rsp: ack=%b rdata=%h perr=%b required 001 0bc11477 0",
               bus.RSP_ACK, bus.RSP_RDATA, bus.RSP_PERR); end
    checks++;
    if (obs_lat !== 385) begin errors++;
      $display("FAIL idcode_latency: got %0d required 385", obs_lat); end
    checks++;
    if (obs_n !== exp_n || obs_stream !== exp_stream || obs_oe !== exp_oe) begin errors++;
      $display("FAIL idcode_stream: n=%0d di=%h oe=%h required n=%0d di=%h oe=%h",
               obs_n, obs_stream, obs_oe, exp_n, exp_stream, exp_oe); end
    held = bus.RSP_RDATA;
    @(posedge CLK); #1;
    checks++;
    if (bus.RSP_VALID !== 1'b0 || bus.RSP_RDATA !== 32'h0BC11477) begin errors++;
      $display("FAIL rsp_pulse: valid=%b rdata=%h required 0 %h", bus.RSP_VALID, bus.RSP_RDATA, held); end
  endtask

  task automatic test_select_write();
    run_xfer(1'b0, 1'b0, 2'b10, 32'h000000F0, 3'b001, 32'd0, 1'b0);
    checks++;
    if (obs_stream[7:0] !== 8'hB1) begin errors++;
      $display("FAIL select_req: got %h required b1", obs_stream[7:0]); end
    checks++;
    if (obs_stream[45:13] !== {1'b0, 32'h000000F0}) begin errors++;
      $display("FAIL select_wdata: got %h required 0f0", obs_stream[45:13]); end
    checks++;
    if (obs_n !== 48 || obs_oe[47:0] !== 48'hFFFF_FFFF_E0FF) begin errors++;
      $display("FAIL select_oe: n=%0d oe=%h required 48 ffffffffe0ff", obs_n, obs_oe[47:0]); end
    checks++;
    if (bus.RSP_ACK !== 3'b001 || bus.RSP_RDATA !== 32'd0 || obs_lat !== 385) begin errors++;
      $display("FAIL select_rsp: ack=%b rdata=%h lat=%0d required 001 0 385",
               bus.RSP_ACK, bus.RSP_RDATA, obs_lat); end
  endtask

  task automatic test_ap_wait();
    run_xfer(1'b1, 1'b1, 2'b11, 32'd0, 3'b010, 32'hDEADBEEF, 1'b0);
    checks++;
    if (obs_stream[7:0] !== 8'h9F) begin errors++;
      $display("FAIL wait_req: got %h required 9f", obs_stream[7:0]); end
    checks++;
    if (bus.RSP_ACK !== 3'b010 || bus.RSP_RDATA !== 32'd0 || bus.RSP_PERR !== 1'b0) begin errors++;
      $display("FAIL wait_rsp: ack=%b rdata=%h perr=%b required 010 0 0",
               bus.RSP_ACK, bus.RSP_RDATA, bus.RSP_PERR); end
    checks++;
    if (obs_lat !== 121 || obs_n !== 15) begin errors++;
      $display("FAIL wait_len: lat=%0d slots=%0d required 121 15", obs_lat, obs_n); end
  endtask

  task automatic test_bad_parity();
    run_xfer(1'b0, 1'b1, 2'b00, 32'd0, 3'b001, 32'h00000001, 1'b1);
    checks++;
    if (bus.RSP_PERR !== 1'b1 || bus.RSP_RDATA !== 32'h00000001) begin errors++;
      $display("FAIL bad_parity: perr=%b rdata=%h required 1 00000001", bus.RSP_PERR, bus.RSP_RDATA); end
  endtask

  task automatic test_random();
    logic [2:0] acks [5];
    acks[0] = 3'b001; acks[1] = 3'b010; acks[2] = 3'b100; acks[3] = 3'b111; acks[4] = 3'b000;
    for (int t = 0; t < 10; t++) begin
      logic ap, rnw, flip;
      logic [1:0] addr;
      logic [2:0] ack;
      logic [31:0] wd, td;
      ap = 1'($urandom); rnw = 1'($urandom); flip = 1'($urandom);
      addr = 2'($urandom); wd = $urandom; td = $urandom;
      ack = (t < 4) ? 3'b001 : acks[$urandom_range(0, 4)];
      run_xfer(ap, rnw, addr, wd, ack, td, flip);
      checks++;
      if (bus.RSP_ACK !== exp_ack || bus.RSP_RDATA !== exp_rdata || bus.RSP_PERR !== exp_perr) begin
        errors++;
        $display("FAIL rand_rsp[%0d]: ack=%b rdata=%h perr=%b required %b %h %b", t,
                 bus.RSP_ACK, bus.RSP_RDATA, bus.RSP_PERR, exp_ack, exp_rdata, exp_perr); end
      checks++;
      if (obs_lat !== exp_lat) begin errors++;
        $display("FAIL rand_latency[%0d]: got %0d required %0d", t, obs_lat, exp_lat); end
      checks++;
      if (obs_n !== exp_n || obs_stream !== exp_stream || obs_oe !== exp_oe) begin errors++;
        $display("FAIL rand_stream[%0d]: n=%0d di=%h oe=%h required n=%0d di=%h oe=%h", t,
                 obs_n, obs_stream, obs_oe, exp_n, exp_stream, exp_oe); end
    end
  endtask

  task automatic test_back_to_back();
    int first_rsp;
    base = host_q.size();
    model_lreset();
    issue(2'b01, 1'b0, 1'b0, 2'b00, 32'd0);
    wait_rsp();
    first_rsp = rsp_cyc;
    pack();
    checks++;
    if (obs_stream[57:0] !== {2'b00, 56'hFF_FFFF_FFFF_FFFF} || obs_oe[57:0] !== exp_oe[57:0]) begin
      errors++;
      $display("FAIL lreset_stream: di=%h oe=%h required 00ffffffffffffff all-oe",
               obs_stream[57:0], obs_oe[57:0]); end
    checks++;
    if (bus.RSP_ACK !== 3'b000 || bus.RSP_PERR !== 1'b0 || obs_lat !== 465 || bus.CMD_READY !== 1'b1) begin
      errors++;
      $display("FAIL lreset_rsp: ack=%b perr=%b lat=%0d ready=%b required 000 0 465 1",
               bus.RSP_ACK, bus.RSP_PERR, obs_lat, bus.CMD_READY); end
    base = base + 58;
    model_xfer(1'b0, 1'b1, 2'b00, 32'd0, 3'b001, 32'h0BC11477, 1'b0);
    issue(2'b00, 1'b0, 1'b1, 2'b00, 32'd0);
    checks++;
    if (acc_cyc !== first_rsp + 1) begin errors++;
      $display("FAIL b2b_accept: accepted at %0d required %0d", acc_cyc, first_rsp + 1); end
    wait_rsp();
    pack();
    checks++;
    if (obs_stream[7:0] !== 8'hA5 || bus.RSP_RDATA !== 32'h0BC11477 || obs_lat !== 385) begin errors++;
      $display("FAIL b2b_read: req=%h rdata=%h lat=%0d required a5 0bc11477 385",
               obs_stream[7:0], bus.RSP_RDATA, obs_lat); end
  endtask

  task automatic test_reset_mid_op();
    int nrv;
    base = host_q.size();
    model_xfer(1'b0, 1'b1, 2'b00, 32'd0, 3'b001, 32'h12345678, 1'b0);
    issue(2'b00, 1'b0, 1'b1, 2'b00, 32'd0);
    repeat (100) @(posedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if ({SWCLKTCK, SWDITMS, SWDIOOE, bus.CMD_READY, bus.RSP_VALID} !== 5'b00110) begin errors++;
      $display("FAIL abort_state: sck/di/oe/ready/valid=%b required 00110",
               {SWCLKTCK, SWDITMS, SWDIOOE, bus.CMD_READY, bus.RSP_VALID}); end
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    nrv = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge CLK); #1;
      if (bus.RSP_VALID === 1'b1) nrv++;
    end
    checks++;
    if (nrv !== 0 || SWCLKTCK !== 1'b0) begin errors++;
      $display("FAIL abort_quiet: rsp_valid pulses=%0d sck=%b required 0 0", nrv, SWCLKTCK); end
    run_xfer(1'b0, 1'b1, 2'b00, 32'd0, 3'b001, 32'h0BC11477, 1'b0);
    checks++;
    if (bus.RSP_ACK !== 3'b001 || bus.RSP_RDATA !== 32'h0BC11477 || obs_lat !== 385) begin errors++;
      $display("FAIL post_reset_read: ack=%b rdata=%h lat=%0d required 001 0bc11477 385",
               bus.RSP_ACK, bus.RSP_RDATA, obs_lat); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) plan[i] = 1'b1;
    bus.CMD_VALID = 1'b0; bus.CMD_OP = 2'b00; bus.CMD_APnDP = 1'b0;
    bus.CMD_RnW = 1'b0; bus.CMD_ADDR = 2'b00; bus.CMD_WDATA = 32'd0;
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    test_reset();
    RESET = 1'b0;
    @(posedge CLK); #1;
    test_idcode_read();
    test_select_write();
    test_ap_wait();
    test_bad_parity();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
